bnn_seq_ctrl: RTL and testbench
===============================

Name: bnn_seq_ctrl

Overview:
- Parametrised instruction sequencer for the BNN core; successor to the single-cycle BPU controller.
- Fetches 16-bit instructions from instruction SRAM with a req/valid handshake and keeps a program counter, NREG general registers and a compare flag.
- Decodes each instruction into a one-cycle-valid control word for the BNN core, and stalls while the core reports busy.
- Sits between instruction SRAM, the BNN core control input and the host start/halt interface.

Parameters:
- PC_W, 16, program counter and instruction-address width.
- NREG, 4, number of 16-bit general registers (power of 2, 2..8).
- CTRL_W, 17, BNN core control word width (at least 17).
- IMEM_LAT_MAX, 15, fetch cycles waited before the fetch-timeout error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; in IDLE or HALT, loads pc from start_pc and begins fetching.
- start_pc  in  PC_W  program entry address.
- imem_req  out  1  fetch request; held until imem_vld.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_vld  in  1  imem_data valid for one cycle.
- imem_data  in  16  fetched instruction.
- core_busy  in  1  BNN core cannot accept a control word.
- ctrl_vld  out  1  ctrl_word valid for exactly this cycle.
- ctrl_word  out  CTRL_W  BNN core control bits (bit map in package).
- halted  out  1  sequencer is in HALT.
- err  out  1  sticky: fetch timeout or illegal opcode.

Behaviour:
- Reset values: pc=0; regs=0; flag=0; imem_req=0; imem_addr=0; ctrl_vld=0; ctrl_word=0; halted=0; err=0. State=IDLE.
- State IDLE: waits for start. On start: pc<=start_pc, go to FETCH.
- State FETCH: imem_req=1, imem_addr=pc.
  - On imem_vld: latch the instruction, go to EXEC.
  - If the wait counter reaches IMEM_LAT_MAX: err<=1, go to HALT.
- State EXEC: one cycle; decodes opcode inst[15:11]. Default action pc<=pc+1, then FETCH.
- State ISSUE: entered from EXEC by control-emitting opcodes.
  - If core_busy=0: ctrl_vld=1 for one cycle with the decoded word, pc<=pc+1, go to FETCH.
  - If core_busy=1: hold in ISSUE with ctrl_vld=0.
- Latency: a non-control instruction takes at least 2 cycles (fetch plus EXEC); a control instruction takes at least 3.
- Opcodes:
  - 00000 NOP.
  - 00001 LDL: reg[inst[10:8]][7:0]<=inst[7:0].
  - 00010 LDH: reg[inst[10:8]][15:8]<=inst[7:0].
  - For LDL/LDH, a register index >= NREG is ignored.
  - 00011 LOAD2 (ISSUE):
    - inst[10:9]=00: weight, bit7=1, bits[2:1]=inst[8:7].
    - inst[10:9]=01: bias, bit11=1.
    - inst[10:9]=10: image, bit8=1, bits[2:1]=inst[8:7], bit16=inst[6].
    - inst[10:9]=11: illegal.
  - 00100 ADDI: reg[inst[10:9]] += sign-extended inst[8:0]; wraps modulo 2^16.
  - 00101 CMP: flag<=(reg[inst[10:9]] > zero-extended inst[8:0]), unsigned; registers unchanged.
  - 00110 JMPB: if flag, pc<=pc-inst[10:0] (modulo 2^PC_W); else pc+1. Offset 0 with flag=1 is a legal self-loop.
  - 00111 EMPT: bit0=1 (ISSUE).
  - 01000 BPUE ADD: bit5=1, bits[3:1]=inst[10:8] (ISSUE).
  - 01001 BPUC ADD: bit9=1, bits[4:1]=inst[10:7] (ISSUE).
  - 01010 OUT: bit10=1, bit12=inst[10], bit6=inst[9], bit13=inst[8] (ISSUE).
  - 01011 STORE: bit14=1, bit6=inst[10] (ISSUE).
  - 01100 SHIFT: bit15=1 (ISSUE).
  - 01101 SEL: bit16=inst[10] (ISSUE).
  - 11111 HALT: go to HALT with pc unchanged.
  - Any other opcode: err<=1, go to HALT.
- Control word: every bit not listed for an opcode is 0.
- State HALT: halted=1. On start: err<=0, pc<=start_pc, go to FETCH.
- Simultaneous events:
  - start outside IDLE/HALT is ignored.
  - imem_vld while not in FETCH is ignored.
- Reset mid-operation: asynchronous return to reset values, including mid-fetch and mid-stall.

Optional Feature:
- Macro: BNN_SEQ_HWLOOP_EN.
- When defined, adds a 10-bit loop counter, reset to 0:
  - 01110 LOOP: cnt<=inst[9:0].
  - 01111 DJNZ: if cnt!=0, then cnt<=cnt-1 and pc<=pc-inst[10:0]; else pc+1.
- When not defined, 01110 and 01111 are illegal: err<=1, go to HALT.

Decomposition:
- Package bnn_seq_pkg holds:
  - opcode localparams;
  - the state enum;
  - control-bit index constants (weight, bias, image, empty, bpue, bpuc, out, store, shift, sel);
  - the CTRL_W default.
- Sub-module bnn_seq_decode: purely combinational; instruction in, control word plus class (reg-op, branch, issue, halt, illegal) out.

Test Plan:
- LDL r1 0x34, LDH r1 0x12, ADDI r1 -1 (0x1FF), CMP r1 0 -> r1=0x1233, flag=1, no ctrl_vld.
- LOAD2 image, inst[8:7]=2, inst[6]=1, with core_busy high 5 cycles -> ctrl_vld after busy drops, word bits8,2,16 set, pc+1 only once.
- Loop body 3 instructions + ADDI r2 -1, CMP r2 0, JMPB 5 with r2=4 -> body executes 4 times, then falls through.
- imem_vld withheld for 16 cycles -> err=1, halted=1; a start pulse clears err and resumes at start_pc.
- rst asserted mid-ISSUE -> ctrl_vld=0 and pc=0 immediately; opcode 10000 -> err=1, halted=1.
- With BNN_SEQ_HWLOOP_EN: LOOP 2, EMPT, DJNZ 1 -> exactly 3 EMPT pulses; without it, LOOP sets err.

Source files
------------

// File: rtl/bnn_seq_pkg.sv
// ============================================================================
//  Module      : bnn_seq_pkg
//  Description : Shared opcodes, FSM states, instruction classes and control
//                word bit positions for the BNN instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_seq_pkg;

    localparam int CTRL_W_DEF = 17;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LDL   = 5'b00001;
    localparam logic [4:0] OP_LDH   = 5'b00010;
    localparam logic [4:0] OP_LOAD2 = 5'b00011;
    localparam logic [4:0] OP_ADDI  = 5'b00100;
    localparam logic [4:0] OP_CMP   = 5'b00101;
    localparam logic [4:0] OP_JMPB  = 5'b00110;
    localparam logic [4:0] OP_EMPT  = 5'b00111;
    localparam logic [4:0] OP_BPUE  = 5'b01000;
    localparam logic [4:0] OP_BPUC  = 5'b01001;
    localparam logic [4:0] OP_OUT   = 5'b01010;
    localparam logic [4:0] OP_STORE = 5'b01011;
    localparam logic [4:0] OP_SHIFT = 5'b01100;
    localparam logic [4:0] OP_SEL   = 5'b01101;
    localparam logic [4:0] OP_LOOP  = 5'b01110;
    localparam logic [4:0] OP_DJNZ  = 5'b01111;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    typedef enum logic [2:0] {
        CLS_REG     = 3'd0,
        CLS_BRANCH  = 3'd1,
        CLS_ISSUE   = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } cls_t;

    localparam int BIT_EMPTY  = 0;
    localparam int BIT_SUB_LO = 1;
    localparam int BIT_BPUE   = 5;
    localparam int BIT_OUT_A  = 6;
    localparam int BIT_WEIGHT = 7;
    localparam int BIT_IMAGE  = 8;
    localparam int BIT_BPUC   = 9;
    localparam int BIT_OUT    = 10;
    localparam int BIT_BIAS   = 11;
    localparam int BIT_OUT_B  = 12;
    localparam int BIT_OUT_C  = 13;
    localparam int BIT_STORE  = 14;
    localparam int BIT_SHIFT  = 15;
    localparam int BIT_SEL    = 16;

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_seq_decode.sv
// ============================================================================
//  Module      : bnn_seq_decode
//  Description : Combinational decoder: instruction to BNN control word and
//                instruction class. Macro BNN_SEQ_HWLOOP_EN makes LOOP/DJNZ legal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_seq_decode
    import bnn_seq_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic [15:6]       inst,
    output logic [CTRL_W-1:0] ctrl_word,
    output cls_t              cls
);

    logic [16:0] w;

    always_comb begin
        w   = '0;
        cls = CLS_REG;
        case (inst[15:11])
            OP_NOP, OP_LDL, OP_LDH, OP_ADDI, OP_CMP: cls = CLS_REG;
            OP_JMPB: cls = CLS_BRANCH;
            OP_LOAD2: begin
                cls = CLS_ISSUE;
                case (inst[10:9])
                    2'b00: begin
                        w[BIT_WEIGHT]           = 1'b1;
                        w[BIT_SUB_LO+1:BIT_SUB_LO] = inst[8:7];
                    end
                    2'b01: w[BIT_BIAS] = 1'b1;
                    2'b10: begin
                        w[BIT_IMAGE]            = 1'b1;
                        w[BIT_SUB_LO+1:BIT_SUB_LO] = inst[8:7];
                        w[BIT_SEL]              = inst[6];
                    end
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_EMPT: begin
                cls            = CLS_ISSUE;
                w[BIT_EMPTY]   = 1'b1;
            end
            OP_BPUE: begin
                cls                        = CLS_ISSUE;
                w[BIT_BPUE]                = 1'b1;
                w[BIT_SUB_LO+2:BIT_SUB_LO] = inst[10:8];
            end
            OP_BPUC: begin
                cls                        = CLS_ISSUE;
                w[BIT_BPUC]                = 1'b1;
                w[BIT_SUB_LO+3:BIT_SUB_LO] = inst[10:7];
            end
            OP_OUT: begin
                cls          = CLS_ISSUE;
                w[BIT_OUT]   = 1'b1;
                w[BIT_OUT_B] = inst[10];
                w[BIT_OUT_A] = inst[9];
                w[BIT_OUT_C] = inst[8];
            end
            OP_STORE: begin
                cls          = CLS_ISSUE;
                w[BIT_STORE] = 1'b1;
                w[BIT_OUT_A] = inst[10];
            end
            OP_SHIFT: begin
                cls          = CLS_ISSUE;
                w[BIT_SHIFT] = 1'b1;
            end
            OP_SEL: begin
                cls        = CLS_ISSUE;
                w[BIT_SEL] = inst[10];
            end
`ifdef BNN_SEQ_HWLOOP_EN
            OP_LOOP, OP_DJNZ: cls = CLS_BRANCH;
`endif
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILLEGAL;
        endcase
        // Illegal encodings never drive any control bit.
        if (cls == CLS_ILLEGAL) begin
            w = '0;
        end
    end

    assign ctrl_word = CTRL_W'(w);

endmodule

`default_nettype wire

// File: rtl/bnn_seq_ctrl.sv
// ============================================================================
//  Module      : bnn_seq_ctrl
//  Description : BNN core instruction sequencer: fetch / exec / issue FSM with
//                registers, compare flag and optional hardware loop counter
//                (macro BNN_SEQ_HWLOOP_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_seq_ctrl
    import bnn_seq_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int NREG         = 4,
    parameter int CTRL_W       = CTRL_W_DEF,
    parameter int IMEM_LAT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_vld,
    input  logic [15:0]       imem_data,
    input  logic              core_busy,
    output logic              ctrl_vld,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              halted,
    output logic              err
);

    localparam int RIDX_W = (NREG < 2) ? 1 : $clog2(NREG);
    localparam int WCNT_W = (IMEM_LAT_MAX < 2) ? 1 : $clog2(IMEM_LAT_MAX + 1);

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       inst_q, inst_d;
    logic [15:0]       regs_q [NREG];
    logic [15:0]       regs_d [NREG];
    logic              flag_q, flag_d;
    logic              err_q, err_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
`ifdef BNN_SEQ_HWLOOP_EN
    logic [9:0]        cnt_q, cnt_d;
`endif

    logic [CTRL_W-1:0] dec_word;
    cls_t              dec_cls;
    logic [2:0]        ld_idx, ar_idx;
    logic              ld_ok, ar_ok;
    logic [15:0]       ar_val;
    logic [PC_W-1:0]   pc_inc, pc_back;

    bnn_seq_decode #(
        .CTRL_W (CTRL_W)
    ) u_decode (
        .inst      (inst_q[15:6]),
        .ctrl_word (dec_word),
        .cls       (dec_cls)
    );

    assign ld_idx  = inst_q[10:8];
    assign ar_idx  = {1'b0, inst_q[10:9]};
    assign ld_ok   = 32'(ld_idx) < NREG;
    assign ar_ok   = 32'(ar_idx) < NREG;
    assign ar_val  = ar_ok ? regs_q[ar_idx[RIDX_W-1:0]] : 16'h0000;
    assign pc_inc  = pc_q + PC_W'(1);
    assign pc_back = pc_q - PC_W'(inst_q[10:0]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        regs_d  = regs_q;
        flag_d  = flag_q;
        err_d   = err_q;
        wcnt_d  = '0;
`ifdef BNN_SEQ_HWLOOP_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_vld) begin
                    inst_d  = imem_data;
                    state_d = ST_EXEC;
                end else if (wcnt_q == WCNT_W'(IMEM_LAT_MAX)) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end
            ST_EXEC: begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
                case (dec_cls)
                    CLS_ISSUE: begin
                        pc_d    = pc_q;
                        state_d = ST_ISSUE;
                    end
                    CLS_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    CLS_ILLEGAL: begin
                        pc_d    = pc_q;
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end
                    default: begin
                        case (inst_q[15:11])
                            OP_LDL: if (ld_ok) regs_d[ld_idx[RIDX_W-1:0]][7:0]  = inst_q[7:0];
                            OP_LDH: if (ld_ok) regs_d[ld_idx[RIDX_W-1:0]][15:8] = inst_q[7:0];
                            OP_ADDI: if (ar_ok) regs_d[ar_idx[RIDX_W-1:0]] = ar_val + sext9(inst_q[8:0]);
                            OP_CMP: flag_d = ar_val > {7'd0, inst_q[8:0]};
                            OP_JMPB: if (flag_q) pc_d = pc_back;
`ifdef BNN_SEQ_HWLOOP_EN
                            OP_LOOP: cnt_d = inst_q[9:0];
                            OP_DJNZ: begin
                                if (cnt_q != 10'd0) begin
                                    cnt_d = cnt_q - 10'd1;
                                    pc_d  = pc_back;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                endcase
            end
            ST_ISSUE: begin
                if (!core_busy) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    err_d   = 1'b0;
                    pc_d    = start_pc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
`ifdef BNN_SEQ_HWLOOP_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
            regs_q  <= regs_d;
`ifdef BNN_SEQ_HWLOOP_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // The control word is only driven while it is being accepted by the core.
    assign ctrl_vld  = (state_q == ST_ISSUE) && !core_busy;
    assign ctrl_word = ctrl_vld ? dec_word : '0;
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bnn_seq_ctrl.sv
// ============================================================================
//  Module      : tb_bnn_seq_ctrl
//  Description : Directed self-checking bench for bnn_seq_ctrl with an
//                instruction memory model (BNN_SEQ_HWLOOP_EN selects the loop test).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bnn_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] start_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_vld;
    logic [15:0] imem_data;
    logic        core_busy;
    logic        ctrl_vld;
    logic [16:0] ctrl_word;
    logic        halted;
    logic        err;

    logic [15:0] mem [0:255];
    logic        withhold;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pulse = 0;
    int          n_empt = 0;
    int          n_shift = 0;
    logic [16:0] last_word = '0;
    int          p0, e0, s0;

    bnn_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_pc  (start_pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_vld  (imem_vld),
        .imem_data (imem_data),
        .core_busy (core_busy),
        .ctrl_vld  (ctrl_vld),
        .ctrl_word (ctrl_word),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Zero-latency SRAM model; withhold stalls it indefinitely.
    assign imem_vld  = imem_req && !withhold;
    assign imem_data = mem[imem_addr[7:0]];

    always @(negedge clk) begin
        if (ctrl_vld) begin
            n_pulse   = n_pulse + 1;
            n_empt    = n_empt + int'(ctrl_word[0]);
            n_shift   = n_shift + int'(ctrl_word[15]);
            last_word = ctrl_word;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] pc);
        @(negedge clk);
        start_pc = pc;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int k;
        k = 0;
        while (!halted && k < 400) begin
            @(posedge clk);
            #1;
            k = k + 1;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hF800;
        // register ops: LDL r1 34, LDH r1 12, ADDI r1 -1, CMP r1 0
        mem[8'h00] = 16'h0934; mem[8'h01] = 16'h1112; mem[8'h02] = 16'h23FF;
        mem[8'h03] = 16'h2A00; mem[8'h04] = 16'hF800;
        // LOAD2 image, sub=2, bit16=1
        mem[8'h10] = 16'h1D40; mem[8'h11] = 16'hF800;
        // r2=4; body EMPT,SHIFT,NOP; ADDI r2 -1; CMP r2 0; JMPB 5
        mem[8'h20] = 16'h0A04; mem[8'h21] = 16'h3800; mem[8'h22] = 16'h6000;
        mem[8'h23] = 16'h0000; mem[8'h24] = 16'h25FF; mem[8'h25] = 16'h2C00;
        mem[8'h26] = 16'h3005; mem[8'h27] = 16'hF800;
        mem[8'h40] = 16'h8000;
        // LOOP 2; EMPT; DJNZ 1
        mem[8'h48] = 16'h7002; mem[8'h49] = 16'h3800; mem[8'h4A] = 16'h7801;
        mem[8'h4B] = 16'hF800;

        rst = 1'b1; start = 1'b0; start_pc = '0; core_busy = 1'b0; withhold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",    32'(imem_req),  32'd0);
        check("rst_addr",   32'(imem_addr), 32'd0);
        check("rst_vld",    32'(ctrl_vld),  32'd0);
        check("rst_word",   32'(ctrl_word), 32'd0);
        check("rst_halted", 32'(halted),    32'd0);
        check("rst_err",    32'(err),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        p0 = n_pulse;
        pulse_start(16'h0000);
        wait_halt("t1_halt");
        check("t1_r1",     32'(dut.regs_q[1]), 32'h1233);
        check("t1_flag",   32'(dut.flag_q),    32'd1);
        check("t1_pulses", 32'(n_pulse - p0),  32'd0);
        check("t1_pc",     32'(imem_addr),     32'h4);
        check("t1_err",    32'(err),           32'd0);

        core_busy = 1'b1;
        p0 = n_pulse;
        pulse_start(16'h0010);
        repeat (5) @(posedge clk);
        #1;
        check("t2_busy_pulses", 32'(n_pulse - p0), 32'd0);
        check("t2_busy_pc",     32'(imem_addr),    32'h10);
        check("t2_busy_vld",    32'(ctrl_vld),     32'd0);
        core_busy = 1'b0;
        wait_halt("t2_halt");
        check("t2_pulses", 32'(n_pulse - p0), 32'd1);
        check("t2_word",   32'(last_word),    32'h10104);
        check("t2_pc",     32'(imem_addr),    32'h11);

        p0 = n_pulse; e0 = n_empt; s0 = n_shift;
        pulse_start(16'h0020);
        wait_halt("t3_halt");
        check("t3_empt",   32'(n_empt - e0),   32'd4);
        check("t3_shift",  32'(n_shift - s0),  32'd4);
        check("t3_pulses", 32'(n_pulse - p0),  32'd8);
        check("t3_pc",     32'(imem_addr),     32'h27);
        check("t3_r2",     32'(dut.regs_q[2]), 32'h0);
        check("t3_flag",   32'(dut.flag_q),    32'd0);

        withhold = 1'b1;
        pulse_start(16'h0030);
        repeat (15) @(posedge clk);
        #1;
        check("t4_not_yet", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_err",    32'(err),    32'd1);
        withhold = 1'b0;
        pulse_start(16'h0000);
        check("t4_err_clr", 32'(err),    32'd0);
        check("t4_resume",  32'(halted), 32'd0);
        wait_halt("t4_halt2");
        check("t4_pc", 32'(imem_addr), 32'h4);

        core_busy = 1'b1;
        pulse_start(16'h0010);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 core_busy = 1'b0;
        #1 check("t5_pre_vld", 32'(ctrl_vld), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_vld",  32'(ctrl_vld),  32'd0);
        check("t5_word", 32'(ctrl_word), 32'd0);
        check("t5_pc",   32'(imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t5_idle", 32'(imem_req), 32'd0);

        pulse_start(16'h0040);
        wait_halt("ill_halt");
        check("ill_err", 32'(err),       32'd1);
        check("ill_pc",  32'(imem_addr), 32'h40);

        e0 = n_empt;
        pulse_start(16'h0048);
        wait_halt("t6_halt");
`ifdef BNN_SEQ_HWLOOP_EN
        check("t6_empt", 32'(n_empt - e0), 32'd3);
        check("t6_err",  32'(err),         32'd0);
        check("t6_pc",   32'(imem_addr),   32'h4B);
`else
        check("t6_empt", 32'(n_empt - e0), 32'd0);
        check("t6_err",  32'(err),         32'd1);
        check("t6_pc",   32'(imem_addr),   32'h48);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
